// File: rtl/ap_mmio_ctrl.sv
// ap_mmio_ctrl: MMIO front end for one AP_s associative processor core.
// Decodes word-addressed requests into core strobes, settings and a run FSM.
module ap_mmio_ctrl #(
    parameter int WORD_SIZE  = 8,
    parameter int CELL_QUANT = 128,
    parameter int NUM_COLS   = 3,
    parameter int INT_COLS   = 2,
    parameter int TIMEOUT    = 4096,
    parameter int MEM_WORDS  = NUM_COLS * INT_COLS * CELL_QUANT,
    parameter int ADDR_W     = $clog2(MEM_WORDS + 4),
    parameter int CELL_W     = (CELL_QUANT > 1) ? $clog2(CELL_QUANT) : 1,
    parameter int COL_W      = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1,
    parameter int ICOL_W     = (INT_COLS > 1) ? $clog2(INT_COLS) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 io_req_valid,
    output logic                 io_req_ready,
    input  logic [ADDR_W-1:0]    io_req_bits_addr,
    input  logic                 io_req_bits_write,
    input  logic [31:0]          io_req_bits_wdata,
    output logic                 io_resp_valid,
    output logic [31:0]          io_resp_bits_data,
    output logic                 irq,
    output logic [CELL_W-1:0]    ap_addr,
    output logic [WORD_SIZE-1:0] ap_data_in,
    output logic                 ap_write_en,
    output logic                 ap_read_en,
    output logic [COL_W-1:0]     ap_sel_col,
    output logic [ICOL_W-1:0]    ap_sel_internal_col,
    output logic [2:0]           ap_cmd,
    output logic                 ap_op_direction,
    output logic                 ap_mode,
    output logic                 ap_rst,
    input  logic [WORD_SIZE-1:0] ap_data_out,
    input  logic                 ap_done
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_RD_WAIT, S_RUN} state_e;

    state_e state_q, state_d;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  cycles_q, cycles_d;
    logic              done_q, done_d;
    logic              to_q, to_d;
    logic              irq_en_q, irq_en_d;
    logic [2:0]        cmd_q, cmd_d;
    logic              dir_q, dir_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ICOL_W-1:0] icol_q, icol_d;
    logic              ap_rst_q, ap_rst_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_data_q, resp_data_d;

    logic [ADDR_W-1:0] col_full, icol_full, cell_full, off;
    logic              is_mem, reg_hit, in_run;
    logic              accept, mem_acc, mem_wr, mem_rd, set_wr, set_rd;
    logic              wr_mode, wr_ctrl, wr_stat;
    logic              soft_rst, start, run_done, run_to;
    logic [31:0]       rdata;
    logic              unused_bits;

    assign col_full  = io_req_bits_addr / ADDR_W'(INT_COLS * CELL_QUANT);
    assign icol_full = (io_req_bits_addr / ADDR_W'(CELL_QUANT)) % ADDR_W'(INT_COLS);
    assign cell_full = io_req_bits_addr % ADDR_W'(CELL_QUANT);
    assign off       = io_req_bits_addr - ADDR_W'(MEM_WORDS);
    assign is_mem    = io_req_bits_addr < ADDR_W'(MEM_WORDS);
    assign reg_hit   = !is_mem && (off < ADDR_W'(4));
    assign in_run    = (state_q == S_RUN);

    assign accept  = io_req_valid & io_req_ready;
    assign mem_acc = accept & is_mem;
    assign mem_wr  = mem_acc & io_req_bits_write;
    assign mem_rd  = mem_acc & ~io_req_bits_write;
    assign set_wr  = accept & reg_hit & io_req_bits_write;
    assign set_rd  = accept & reg_hit & ~io_req_bits_write;

    assign wr_mode = set_wr && (off[1:0] == 2'd0) && (state_q == S_IDLE);
    assign wr_ctrl = set_wr && (off[1:0] == 2'd1);
    assign wr_stat = set_wr && (off[1:0] == 2'd2);

    // Soft reset beats start and any run outcome in the same cycle.
    assign soft_rst = wr_ctrl & io_req_bits_wdata[0];
    assign start    = wr_ctrl & io_req_bits_wdata[1] & ~io_req_bits_wdata[0]
                    & (state_q == S_IDLE);
    assign run_done = in_run & ap_done & ~soft_rst;
    assign run_to   = in_run & ~ap_done & ~soft_rst
                    & (cnt_q == CNT_W'(TIMEOUT - 1));

    assign unused_bits = ^{io_req_bits_wdata, col_full, icol_full, cell_full, off};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (mem_rd) begin
                    state_d = S_RD_WAIT;
                end else if (start) begin
                    state_d = S_RUN;
                end
            end
            S_RD_WAIT: state_d = S_IDLE;
            S_RUN: begin
                if (soft_rst || run_done || run_to) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        io_req_ready = 1'b0;
        case (state_q)
            S_IDLE:    io_req_ready = 1'b1;
            S_RD_WAIT: io_req_ready = 1'b0;
            S_RUN:     io_req_ready = !is_mem;
            default:   io_req_ready = 1'b0;
        endcase
        if (reset) begin
            io_req_ready = 1'b0;
        end
    end

    always_comb begin
        rdata = '0;
        case (off[1:0])
            2'd0: begin
                rdata[2:0]         = cmd_q;
                rdata[8]           = dir_q;
                rdata[16 +: COL_W] = col_q;
                rdata[24 +: ICOL_W] = icol_q;
            end
            2'd1:    rdata[8]   = irq_en_q;
            2'd2:    rdata[2:0] = {to_q, done_q, in_run};
            default: rdata      = 32'(cycles_q);
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = '0;
        end else if (in_run) begin
            cnt_d = cnt_q + 1'b1;
        end
        cycles_d = run_done ? (cnt_q + 1'b1) : cycles_q;
        // Set beats write-one-to-clear when both land together.
        done_d   = run_done | (done_q & ~(wr_stat & io_req_bits_wdata[1]));
        to_d     = run_to | (to_q & ~(wr_stat & io_req_bits_wdata[2]));
        irq_en_d = wr_ctrl ? io_req_bits_wdata[8] : irq_en_q;
        cmd_d    = wr_mode ? io_req_bits_wdata[2:0] : cmd_q;
        dir_d    = wr_mode ? io_req_bits_wdata[8] : dir_q;
        col_d    = wr_mode ? io_req_bits_wdata[16 +: COL_W] : col_q;
        icol_d   = wr_mode ? io_req_bits_wdata[24 +: ICOL_W] : icol_q;
        ap_rst_d = soft_rst | run_to;
        resp_valid_d = (accept & ~mem_rd) | (state_q == S_RD_WAIT);
        resp_data_d  = '0;
        if (state_q == S_RD_WAIT) begin
            resp_data_d = 32'(ap_data_out);
        end else if (set_rd) begin
            resp_data_d = rdata;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            cycles_q     <= '0;
            done_q       <= 1'b0;
            to_q         <= 1'b0;
            irq_en_q     <= 1'b0;
            cmd_q        <= '0;
            dir_q        <= 1'b0;
            col_q        <= '0;
            icol_q       <= '0;
            ap_rst_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            cnt_q        <= cnt_d;
            cycles_q     <= cycles_d;
            done_q       <= done_d;
            to_q         <= to_d;
            irq_en_q     <= irq_en_d;
            cmd_q        <= cmd_d;
            dir_q        <= dir_d;
            col_q        <= col_d;
            icol_q       <= icol_d;
            ap_rst_q     <= ap_rst_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    // Memory accesses steer the column selects; otherwise MODE drives them.
    assign ap_write_en         = mem_wr;
    assign ap_read_en          = mem_rd;
    assign ap_addr             = mem_acc ? cell_full[CELL_W-1:0] : '0;
    assign ap_data_in          = mem_wr ? io_req_bits_wdata[WORD_SIZE-1:0] : '0;
    assign ap_sel_col          = mem_acc ? col_full[COL_W-1:0] : col_q;
    assign ap_sel_internal_col = mem_acc ? icol_full[ICOL_W-1:0] : icol_q;
    assign ap_cmd              = cmd_q;
    assign ap_op_direction     = dir_q;
    assign ap_mode             = in_run;
    assign ap_rst              = ap_rst_q;
    assign irq                 = irq_en_q & (done_q | to_q);
    assign io_resp_valid       = resp_valid_q;
    assign io_resp_bits_data   = resp_data_q;

endmodule

// File: tb/tb_ap_mmio_ctrl.sv
// tb_ap_mmio_ctrl: directed bench for ap_mmio_ctrl with TIMEOUT=16.
// Responses are checked by a monitor against an expectation queue.
`timescale 1ns/1ps
module tb_ap_mmio_ctrl;
    localparam int AW = 10;
    localparam int S  = 768;

    logic          clock = 1'b0;
    logic          reset;
    logic          io_req_valid;
    logic          io_req_ready;
    logic [AW-1:0] io_req_bits_addr;
    logic          io_req_bits_write;
    logic [31:0]   io_req_bits_wdata;
    logic          io_resp_valid;
    logic [31:0]   io_resp_bits_data;
    logic          irq;
    logic [6:0]    ap_addr;
    logic [7:0]    ap_data_in;
    logic          ap_write_en;
    logic          ap_read_en;
    logic [1:0]    ap_sel_col;
    logic [0:0]    ap_sel_internal_col;
    logic [2:0]    ap_cmd;
    logic          ap_op_direction;
    logic          ap_mode;
    logic          ap_rst;
    logic [7:0]    ap_data_out = 8'h00;
    logic          ap_done;

    ap_mmio_ctrl #(.TIMEOUT(16)) dut (
        .clock(clock), .reset(reset),
        .io_req_valid(io_req_valid), .io_req_ready(io_req_ready),
        .io_req_bits_addr(io_req_bits_addr),
        .io_req_bits_write(io_req_bits_write),
        .io_req_bits_wdata(io_req_bits_wdata),
        .io_resp_valid(io_resp_valid),
        .io_resp_bits_data(io_resp_bits_data),
        .irq(irq), .ap_addr(ap_addr), .ap_data_in(ap_data_in),
        .ap_write_en(ap_write_en), .ap_read_en(ap_read_en),
        .ap_sel_col(ap_sel_col),
        .ap_sel_internal_col(ap_sel_internal_col),
        .ap_cmd(ap_cmd), .ap_op_direction(ap_op_direction),
        .ap_mode(ap_mode), .ap_rst(ap_rst),
        .ap_data_out(ap_data_out), .ap_done(ap_done)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Minimal core: cell store with one-cycle read latency.
    logic [7:0] cmem [0:1023];
    always @(posedge clock) begin
        if (ap_write_en) cmem[{ap_sel_col, ap_sel_internal_col, ap_addr}] <= ap_data_in;
        if (ap_read_en) ap_data_out <= cmem[{ap_sel_col, ap_sel_internal_col, ap_addr}];
    end

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t sbq[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (io_resp_valid === 1'b1) begin
            n_vec++;
            if (sbq.size() == 0) begin
                n_err++;
                $display("FAIL resp_unexpected: got 0x%08h at cycle %0d, want none",
                         io_resp_bits_data, cyc);
            end else begin
                e = sbq.pop_front();
                if (io_resp_bits_data !== e.data || cyc != e.cyc) begin
                    n_err++;
                    $display("FAIL resp: got 0x%08h at cycle %0d, want 0x%08h at cycle %0d",
                             io_resp_bits_data, cyc, e.data, e.cyc);
                end
            end
        end
    end

    // lat: response cycle offset from the accept cycle; 0 = no response expected.
    task automatic issue(input int addr, input logic wr, input logic [31:0] wd,
                         input logic [31:0] exp, input int lat, output int acc);
        io_req_valid      = 1'b1;
        io_req_bits_addr  = AW'(addr);
        io_req_bits_write = wr;
        io_req_bits_wdata = wd;
        acc = -1;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (io_req_ready === 1'b1) begin
                acc = cyc;
                break;
            end
            @(negedge clock);
        end
        if (acc < 0) begin
            n_vec++;
            n_err++;
            $display("FAIL req_accept: got no ready for addr %0d, want accept", addr);
            io_req_valid = 1'b0;
        end else if (lat > 0) begin
            sbq.push_back('{data: exp, cyc: acc + lat});
        end
    endtask

    task automatic complete();
        @(posedge clock);
        @(negedge clock);
        io_req_valid      = 1'b0;
        io_req_bits_write = 1'b0;
        io_req_bits_wdata = '0;
        #1;
    endtask

    task automatic req(input int addr, input logic wr, input logic [31:0] wd,
                       input logic [31:0] exp);
        int a;
        issue(addr, wr, wd, exp, wr ? 1 : ((addr < S) ? 2 : 1), a);
        complete();
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clock);
    endtask

    int          v_addr [5] = '{390, 127, 128, 767, 512};
    logic [7:0]  v_data [5] = '{8'hA5, 8'h3C, 8'hC3, 8'h5A, 8'h77};
    logic [1:0]  v_col  [5] = '{2'd1, 2'd0, 2'd0, 2'd2, 2'd2};
    logic        v_icol [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [6:0]  v_cell [5] = '{7'd6, 7'd127, 7'd0, 7'd127, 7'd0};

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100us, want finish");
        $fatal(1);
    end

    initial begin
        int a, b, pulses, pcyc;
        reset             = 1'b1;
        io_req_valid      = 1'b0;
        io_req_bits_addr  = '0;
        io_req_bits_write = 1'b0;
        io_req_bits_wdata = '0;
        ap_done           = 1'b0;
        repeat (2) @(negedge clock);
        io_req_valid      = 1'b1;
        io_req_bits_addr  = AW'(390);
        io_req_bits_write = 1'b1;
        io_req_bits_wdata = 32'hA5;
        #1;
        chk("rst_ready", 32'(io_req_ready), 0);
        chk("rst_wen", 32'(ap_write_en), 0);
        chk("rst_col", 32'(ap_sel_col), 0);
        chk("rst_resp_valid", 32'(io_resp_valid), 0);
        chk("rst_mode_irq_rst", 32'({ap_mode, irq, ap_rst}), 0);
        io_req_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // T1 memory writes with decode checks
        for (int i = 0; i < 5; i++) begin
            issue(v_addr[i], 1'b1, 32'(v_data[i]), 0, 1, a);
            chk("wr_wen", 32'(ap_write_en), 1);
            chk("wr_ren", 32'(ap_read_en), 0);
            chk("wr_col", 32'(ap_sel_col), 32'(v_col[i]));
            chk("wr_icol", 32'(ap_sel_internal_col), 32'(v_icol[i]));
            chk("wr_cell", 32'(ap_addr), 32'(v_cell[i]));
            chk("wr_din", 32'(ap_data_in), 32'(v_data[i]));
            complete();
            chk("wr_wen_drop", 32'(ap_write_en), 0);
        end

        // T2 memory reads, 2-cycle latency
        for (int i = 0; i < 5; i++) begin
            issue(v_addr[i], 1'b0, 0, 32'(v_data[i]), 2, a);
            chk("rd_ren", 32'(ap_read_en), 1);
            chk("rd_cell", 32'(ap_addr), 32'(v_cell[i]));
            complete();
            chk("rd_wait_ready", 32'(io_req_ready), 0);
        end

        // Settings and out-of-range
        req(S + 1, 1'b0, 0, 32'h0);
        req(S + 3, 1'b0, 0, 32'h0);
        req(S + 0, 1'b1, 32'h0001_0102, 0);
        req(S + 0, 1'b0, 0, 32'h0001_0102);
        chk("mode_cmd", 32'(ap_cmd), 2);
        chk("mode_dir", 32'(ap_op_direction), 1);
        chk("mode_col", 32'(ap_sel_col), 1);
        chk("mode_icol", 32'(ap_sel_internal_col), 0);
        req(S + 4, 1'b1, 32'hFFFF_FFFF, 0);
        req(S + 4, 1'b0, 0, 32'h0);
        req(1023, 1'b0, 0, 32'h0);

        // T3 run to done with irq
        issue(S + 1, 1'b1, 32'h102, 0, 1, a);
        complete();
        chk("t3_mode_on", 32'(ap_mode), 1);
        req(S + 2, 1'b0, 0, 32'h1);
        wait_until(a + 10);
        ap_done = 1'b1;
        @(negedge clock);
        ap_done = 1'b0;
        #1;
        chk("t3_mode_off", 32'(ap_mode), 0);
        chk("t3_irq", 32'(irq), 1);
        req(S + 2, 1'b0, 0, 32'h2);
        req(S + 3, 1'b0, 0, 32'd10);
        req(S + 1, 1'b0, 0, 32'h100);
        req(S + 2, 1'b1, 32'h2, 0);
        chk("t3_irq_clr", 32'(irq), 0);
        req(S + 2, 1'b0, 0, 32'h0);

        // T5 memory write stalls during a run
        issue(S + 1, 1'b1, 32'h002, 0, 1, a);
        complete();
        fork
            begin
                wait_until(a + 4);
                chk("t5_stall", 32'(io_req_ready), 0);
                wait_until(a + 6);
                ap_done = 1'b1;
                @(negedge clock);
                ap_done = 1'b0;
            end
            begin
                issue(0, 1'b1, 32'h11, 0, 1, b);
                chk("t5_accept_cyc", 32'(b), 32'(a + 7));
                complete();
            end
        join
        chk("t5_irq_masked", 32'(irq), 0);
        req(S + 2, 1'b0, 0, 32'h2);
        req(S + 3, 1'b0, 0, 32'd6);
        req(S + 2, 1'b1, 32'h2, 0);
        req(0, 1'b0, 0, 32'h11);

        // T4 timeout
        issue(S + 1, 1'b1, 32'h102, 0, 1, a);
        complete();
        pulses = 0;
        pcyc   = -1;
        for (int i = 0; i < 25; i++) begin
            if (ap_rst === 1'b1) begin
                pulses++;
                pcyc = cyc;
            end
            if (cyc == a + 16) chk("t4_mode_last", 32'(ap_mode), 1);
            if (cyc == a + 17) chk("t4_mode_off", 32'(ap_mode), 0);
            @(negedge clock);
            #1;
        end
        chk("t4_rst_pulses", 32'(pulses), 1);
        chk("t4_rst_cyc", 32'(pcyc), 32'(a + 17));
        issue(5, 1'b1, 32'h22, 0, 1, b);
        chk("t4_mem_ready", 32'(b), 32'(a + 26));
        complete();
        req(S + 2, 1'b0, 0, 32'h4);
        chk("t4_irq", 32'(irq), 1);
        req(S + 3, 1'b0, 0, 32'd6);
        req(S + 2, 1'b1, 32'h4, 0);
        chk("t4_irq_clr", 32'(irq), 0);

        // done and terminal count together: done wins
        issue(S + 1, 1'b1, 32'h002, 0, 1, a);
        complete();
        wait_until(a + 16);
        ap_done = 1'b1;
        @(negedge clock);
        ap_done = 1'b0;
        #1;
        chk("tie_no_rst", 32'(ap_rst), 0);
        req(S + 2, 1'b0, 0, 32'h2);
        req(S + 3, 1'b0, 0, 32'd16);
        req(S + 2, 1'b1, 32'h2, 0);

        // soft reset aborts a run
        issue(S + 1, 1'b1, 32'h002, 0, 1, a);
        complete();
        wait_until(a + 3);
        issue(S + 1, 1'b1, 32'h001, 0, 1, b);
        complete();
        chk("srst_pulse", 32'(ap_rst), 1);
        chk("srst_mode", 32'(ap_mode), 0);
        @(negedge clock);
        #1;
        chk("srst_pulse_end", 32'(ap_rst), 0);
        req(S + 2, 1'b0, 0, 32'h0);

        // T6 async reset mid-run
        issue(S + 1, 1'b1, 32'h102, 0, 1, a);
        complete();
        wait_until(a + 3);
        #1;
        chk("t6_run_mode", 32'(ap_mode), 1);
        reset = 1'b1;
        #1;
        chk("t6_run_mode_rst", 32'(ap_mode), 0);
        chk("t6_run_ready", 32'(io_req_ready), 0);
        chk("t6_run_resp", 32'(io_resp_valid), 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        req(S + 2, 1'b0, 0, 32'h0);
        req(S + 1, 1'b0, 0, 32'h0);

        // T6 async reset mid-read: the pending response is dropped
        repeat (2) @(negedge clock);
        issue(390, 1'b0, 0, 0, 0, a);
        @(posedge clock);
        @(negedge clock);
        io_req_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("t6_rd_resp", 32'(io_resp_valid), 0);
        chk("t6_rd_ren", 32'(ap_read_en), 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        req(S + 2, 1'b0, 0, 32'h0);
        req(390, 1'b0, 0, 32'hA5);

        repeat (5) @(negedge clock);
        chk("sb_empty", 32'(sbq.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
